// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: sequencer for one scan chain. For each test it shifts a
// stimulus pattern in, pulses one functional capture cycle, shifts the
// response out and counts the bits that differ from an expected word.
// Optional MISR signature over the unloaded bits: define SCAN_TEST_MISR_EN.
//
// Handshake: start is a level request, accepted only on an edge where the
// FSM is in IDLE (busy=0 and done=0). Once accepted, pattern/expected are
// latched and may change freely. busy is high from the accepting edge until
// DONE. done pulses for one cycle when the results are valid. start seen in
// any other state, including DONE, is ignored.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CHAIN_LEN-1:0] response,
  output logic [CNT_W-1:0]     mismatch_cnt,
`ifdef SCAN_TEST_MISR_EN
  output logic [15:0]          signature,
`endif
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_sh;
  logic [CNT_W-1:0]     mm_next;

  // Shift counter reaches the final bit of a LOAD or UNLOAD phase.
  assign last      = (cnt == CNT_W'(CHAIN_LEN-1));
  // Running mismatch count including the bit sampled on this edge.
  assign mm_next   = mismatch_cnt + CNT_W'(scan_out ^ exp_sh[CHAIN_LEN-1]);
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: fixed-length phases counted by cnt.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_LOAD;
      S_LOAD:    if (last)  state_next = S_CAPTURE;
      S_CAPTURE:            state_next = S_UNLOAD;
      S_UNLOAD:  if (last)  state_next = S_DONE;
      S_DONE:               state_next = S_IDLE;
      default:              state_next = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; control outputs follow the next state
  // so they are valid for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_en      <= 1'b0;
      scan_in      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      response     <= '0;
      mismatch_cnt <= '0;
      cnt          <= '0;
      pat_sh       <= '0;
      exp_sh       <= '0;
    end else begin
      scan_en <= (state_next == S_LOAD) || (state_next == S_UNLOAD);
      busy    <= (state_next == S_LOAD) || (state_next == S_CAPTURE) ||
                 (state_next == S_UNLOAD);
      done    <= (state_next == S_DONE);
      cnt     <= ((state_next == state) && ((state == S_LOAD) || (state == S_UNLOAD)))
                 ? cnt + CNT_W'(1) : '0;
      scan_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // MSB goes out first so that it ends up in the last cell.
            scan_in      <= pattern[CHAIN_LEN-1];
            pat_sh       <= {pattern[CHAIN_LEN-2:0], 1'b0};
            exp_sh       <= expected;
            response     <= '0;
            mismatch_cnt <= '0;
            pass         <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!last) begin
            scan_in <= pat_sh[CHAIN_LEN-1];
            pat_sh  <= pat_sh << 1;
          end
        end
        S_UNLOAD: begin
          // Last cell comes out first and lands in the MSB of response.
          response     <= {response[CHAIN_LEN-2:0], scan_out};
          exp_sh       <= exp_sh << 1;
          mismatch_cnt <= mm_next;
          if (last) pass <= (mm_next == '0);
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_TEST_MISR_EN
  logic        misr_fb;
  logic [15:0] sig_next;

  // CRC-16 step (x^16+x^12+x^5+1) over the current unloaded bit.
  assign misr_fb  = signature[15] ^ scan_out;
  assign sig_next = {signature[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);

  // MISR register: seeded to zero on accept, stepped on every unload edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      signature <= 16'h0000;
    end else if ((state == S_IDLE) && start) begin
      signature <= 16'h0000;
    end else if (state == S_UNLOAD) begin
      signature <= sig_next;
    end
  end
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl with an 8-cell inverting scan chain model.
module tb_scan_test_ctrl;

  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  pattern = '0;
  logic [N-1:0]  expected = '0;
  logic          scan_out;
  logic          scan_en;
  logic          scan_in;
  logic          busy;
  logic          done;
  logic          pass;
  logic [N-1:0]  response;
  logic [CW-1:0] mismatch_cnt;
  logic [2:0]    state_dbg;
`ifdef SCAN_TEST_MISR_EN
  logic [15:0]   signature;
`endif

  logic [N-1:0]  chain;

  int checks = 0;
  int errors = 0;

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pattern      (pattern),
    .expected     (expected),
    .scan_out     (scan_out),
    .scan_en      (scan_en),
    .scan_in      (scan_in),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .response     (response),
    .mismatch_cnt (mismatch_cnt),
`ifdef SCAN_TEST_MISR_EN
    .signature    (signature),
`endif
    .state_dbg    (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scan chain of dff_scan cells: shift toward the last cell, or capture ~q.
  assign scan_out = chain[N-1];
  always @(posedge clk) chain <= scan_en ? {chain[N-2:0], scan_in} : ~chain;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference CRC-16/0x1021 over the response, last cell first.
  function automatic logic [15:0] crc_model(input logic [N-1:0] bits);
    logic [15:0] s;
    logic        fb;
    s = 16'h0000;
    for (int i = N-1; i >= 0; i--) begin
      fb = s[15] ^ bits[i];
      s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return s;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".scan_en"}, scan_en, 0);
    check({tag, ".scan_in"}, scan_in, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass, 0);
    check({tag, ".response"}, response, 0);
    check({tag, ".mismatch"}, mismatch_cnt, 0);
    check({tag, ".state"}, state_dbg, 0);
`ifdef SCAN_TEST_MISR_EN
    check({tag, ".signature"}, signature, 0);
`endif
  endtask

  // One full test; call at a negedge with the DUT idle. Returns at the
  // negedge of cycle 2N+3 so the next call is accepted back-to-back.
  task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] exp, input bit hold);
    logic [N-1:0] resp_m;
    int           mm_m;
    resp_m   = ~pat;
    mm_m     = $countones(resp_m ^ exp);
    start    = 1'b1;
    pattern  = pat;
    expected = exp;
    @(posedge clk);
    for (int c = 1; c <= 2*N+3; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) start = 1'b0;
      if (hold && c == 3) begin
        pattern  = ~pat;
        expected = N'($urandom);
      end
      if (hold && c == 2*N+3) start = 1'b0;
      check($sformatf("scan_en@%0d", c), scan_en, (c <= N) || (c >= N+2 && c <= 2*N+1));
      check($sformatf("busy@%0d", c), busy, c <= 2*N+1);
      check($sformatf("done@%0d", c), done, c == 2*N+2);
      if (c >= 2*N+2) begin
        check($sformatf("response@%0d", c), response, resp_m);
        check($sformatf("mismatch@%0d", c), mismatch_cnt, mm_m);
        check($sformatf("pass@%0d", c), pass, mm_m == 0);
`ifdef SCAN_TEST_MISR_EN
        check($sformatf("signature@%0d", c), signature, crc_model(resp_m));
`endif
      end
    end
  endtask

  initial begin
    logic [N-1:0] p;
    logic [N-1:0] e;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_test(8'hA5, 8'h5A, 1'b0);   // pass case
    run_test(8'hA5, 8'h5A, 1'b0);   // identical rerun, same signature
    run_test(8'hA5, 8'h00, 1'b0);   // fail case, 4 mismatches
    run_test(8'h3C, 8'hC3, 1'b1);   // start held, pattern changed mid-load
    run_test(8'h00, 8'h00, 1'b0);   // all bits mismatch

    for (int t = 0; t < 10; t++) begin
      p = N'($urandom);
      e = ($urandom_range(0, 1) == 1) ? ~p : N'($urandom);
      run_test(p, e, 1'b0);
    end

    // Abort mid-unload.
    start   = 1'b1;
    pattern = N'($urandom);
    @(posedge clk);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    check_zero("abort_hold");
    rst = 1'b1;
    @(negedge clk);
    run_test(8'hFF, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
